// File: rtl/sqrt_scheduler.sv
// Round-robin front end that shares one fixed-latency iterative square-root
// datapath between NREQ requesters and returns id-tagged results.
module sqrt_scheduler #(
  parameter int NREQ = 4,
  parameter int W    = 12,
  parameter int LAT  = 18,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic [W-1:0]      resp_q,
  output logic              sqrt_start,
  output logic [W-1:0]      sqrt_a,
  input  logic [W-1:0]      sqrt_q,
  output logic              busy
);

  localparam int CW = $clog2(LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_reg, state_next;
  logic [IDW-1:0]  last_grant_reg;
  logic [IDW-1:0]  id_reg;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    q_reg;
  logic [CW-1:0]   cnt_reg;

  logic            found;
  logic [IDW-1:0]  grant_id;
  logic [W-1:0]    grant_a;

  // Search begins just after the last winner and wraps, so every waiting
  // requester is reached within NREQ grants.
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && req_valid[(int'(last_grant_reg) + k) % NREQ]) begin
        found    = 1'b1;
        grant_id = IDW'((int'(last_grant_reg) + k) % NREQ);
      end
    end
    grant_a = req_a[int'(grant_id)*W +: W];
  end

  always_comb begin
    state_next = state_reg;
    req_ready  = '0;
    case (state_reg)
      IDLE: begin
        // Gated by rst_ so no grant is advertised while reset is held.
        if (found && rst_) begin
          req_ready[grant_id] = 1'b1;
          state_next = (grant_a == '0) ? RESP : ISSUE;
        end
      end
      ISSUE: state_next = WAIT;
      WAIT:  if (cnt_reg == '0) state_next = RESP;
      RESP:  if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_reg      <= IDLE;
      last_grant_reg <= IDW'(NREQ - 1);
      id_reg         <= '0;
      a_reg          <= '0;
      q_reg          <= '0;
      cnt_reg        <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (found) begin
            a_reg          <= grant_a;
            id_reg         <= grant_id;
            last_grant_reg <= grant_id;
            // sqrt(0) is known; the datapath is skipped entirely.
            if (grant_a == '0) q_reg <= '0;
          end
        end
        ISSUE: cnt_reg <= CW'(LAT - 1);
        WAIT: begin
          if (cnt_reg == '0) q_reg <= sqrt_q;
          else               cnt_reg <= cnt_reg - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign sqrt_start = (state_reg == ISSUE);
  assign resp_valid = (state_reg == RESP);
  assign busy       = (state_reg != IDLE);
  assign sqrt_a     = a_reg;
  assign resp_id    = id_reg;
  assign resp_q     = q_reg;

endmodule

// File: tb/tb_sqrt_scheduler.sv
// Directed bench for sqrt_scheduler with a behavioural fixed-latency
// square-root datapath that only presents a valid result in its due cycle.
module tb_sqrt_scheduler;

  localparam int NREQ = 4;
  localparam int W    = 12;
  localparam int LAT  = 18;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic              resp_valid;
  logic              resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [W-1:0]      resp_q;
  logic              sqrt_start;
  logic [W-1:0]      sqrt_a;
  logic [W-1:0]      sqrt_q;
  logic              busy;

  int n_run  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int start_cnt = 0;

  sqrt_scheduler #(.NREQ(NREQ), .W(W), .LAT(LAT)) dut (
    .clk(clk), .rst_(rst_),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_q(resp_q),
    .sqrt_start(sqrt_start), .sqrt_a(sqrt_a), .sqrt_q(sqrt_q),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sqrt_start) start_cnt <= start_cnt + 1;
  end

  // Datapath model: result valid only in the cycle LAT after the start cycle.
  function automatic logic [W-1:0] isqrt(input logic [W-1:0] a);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= int'(a)) r++;
    return W'(r);
  endfunction

  logic [W-1:0] dp_a   = '0;
  int           dp_cnt = 0;
  logic         dp_act = 1'b0;

  always @(posedge clk) begin
    if (sqrt_start) begin
      dp_a   <= sqrt_a;
      dp_cnt <= LAT - 1;
      dp_act <= 1'b1;
    end else if (dp_act) begin
      if (dp_cnt == 0) dp_act <= 1'b0;
      else             dp_cnt <= dp_cnt - 1;
    end
  end

  always_comb begin
    sqrt_q = 12'hABC;
    if (dp_act && dp_cnt == 0) sqrt_q = isqrt(dp_a);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_a(input int i, input logic [W-1:0] v);
    req_a[i*W +: W] = v;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_req_ready"},  32'(req_ready),  0);
    check_eq({tag, "_resp_valid"}, 32'(resp_valid), 0);
    check_eq({tag, "_resp_id"},    32'(resp_id),    0);
    check_eq({tag, "_resp_q"},     32'(resp_q),     0);
    check_eq({tag, "_sqrt_start"}, 32'(sqrt_start), 0);
    check_eq({tag, "_sqrt_a"},     32'(sqrt_a),     0);
    check_eq({tag, "_busy"},       32'(busy),       0);
  endtask

  task automatic wait_ready(output int g);
    for (int i = 0; i < 100; i++) begin
      if (|req_ready) break;
      @(negedge clk); #1;
    end
    check_eq("ready_seen", 32'(|req_ready), 1);
    g = cyc;
  endtask

  task automatic wait_resp(input int exp_id, input int exp_q, output int r);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (resp_valid) break;
    end
    check_eq("resp_seen", 32'(resp_valid), 1);
    check_eq("resp_id", 32'(resp_id), 32'(exp_id));
    check_eq("resp_q",  32'(resp_q),  32'(exp_q));
    r = cyc;
    $display("[TB] resp id=%0d q=%0d cycle=%0d", resp_id, resp_q, cyc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_run);
    $fatal(1, "watchdog");
  end

  int g, r, prev, h, s0;
  int exp_ids[6] = '{0, 2, 3, 0, 2, 3};
  int exp_qs[6]  = '{1, 10, 7, 1, 10, 7};

  initial begin
    rst_ = 1'b0; req_valid = '0; req_a = '0; resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk); rst_ = 1'b1; #1;

    // 1: single nonzero request, latency check
    req_valid = 4'b0001; set_a(0, 144); #1;
    wait_ready(g);
    check_eq("t1_grant", 32'(req_ready), 32'b0001);
    check_eq("t1_busy_idle", 32'(busy), 0);
    @(negedge clk); req_valid = '0; #1;
    check_eq("t1_start", 32'(sqrt_start), 1);
    check_eq("t1_sqrt_a", 32'(sqrt_a), 144);
    check_eq("t1_start_cycle", 32'(cyc - g), 1);
    check_eq("t1_busy_issue", 32'(busy), 1);
    wait_resp(0, 12, r);
    check_eq("t1_latency", 32'(r - g), 20);
    check_eq("t1_busy_resp", 32'(busy), 1);
    @(negedge clk); #1;
    check_eq("t1_valid_drop", 32'(resp_valid), 0);
    check_eq("t1_busy_done", 32'(busy), 0);

    // 2: four simultaneous requests from reset
    rst_ = 1'b0; @(negedge clk); rst_ = 1'b1; #1;
    set_a(0, 4); set_a(1, 9); set_a(2, 16); set_a(3, 25);
    req_valid = 4'b1111; #1;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_ready(g);
      check_eq("t2_grant", 32'(req_ready), 32'(1 << k));
      if (k > 0) check_eq("t2_gap", 32'(g - prev), 21);
      prev = g;
      @(negedge clk); req_valid[k] = 1'b0; #1;
      wait_resp(k, k + 2, r);
    end

    // 3: persistent requesters 0, 2, 3 starting from last_grant = 3
    set_a(0, 1); set_a(2, 100); set_a(3, 49);
    req_valid = 4'b1101; #1;
    for (int j = 0; j < 6; j++) begin
      wait_ready(g);
      check_eq("t3_grant", 32'(req_ready), 32'(1 << exp_ids[j]));
      wait_resp(exp_ids[j], exp_qs[j], r);
    end
    req_valid = '0;

    // 4: zero operand bypasses the datapath
    set_a(1, 0); req_valid = 4'b0010; s0 = start_cnt; #1;
    wait_ready(g);
    check_eq("t4_grant", 32'(req_ready), 32'b0010);
    @(negedge clk); req_valid = '0; #1;
    check_eq("t4_resp_valid", 32'(resp_valid), 1);
    check_eq("t4_resp_id", 32'(resp_id), 1);
    check_eq("t4_resp_q", 32'(resp_q), 0);
    check_eq("t4_resp_cycle", 32'(cyc - g), 1);
    check_eq("t4_no_start", 32'(start_cnt - s0), 0);
    $display("[TB] resp id=%0d q=%0d cycle=%0d", resp_id, resp_q, cyc);

    // 5: response back-pressure with pending requests
    set_a(0, 49); set_a(2, 64); req_valid = 4'b0101; #1;
    wait_ready(g);
    check_eq("t5_grant", 32'(req_ready), 32'b0100);
    resp_ready = 1'b0;
    @(negedge clk); req_valid[2] = 1'b0; #1;
    wait_resp(2, 8, r);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      check_eq("t5_hold_valid", 32'(resp_valid), 1);
      check_eq("t5_hold_id", 32'(resp_id), 2);
      check_eq("t5_hold_q", 32'(resp_q), 8);
      check_eq("t5_hold_ready", 32'(req_ready), 0);
    end
    resp_ready = 1'b1; h = cyc;
    @(negedge clk); #1;
    check_eq("t5_next_grant", 32'(req_ready), 32'b0001);
    check_eq("t5_next_cycle", 32'(cyc - h), 1);
    @(negedge clk); req_valid = '0; #1;
    wait_resp(0, 7, r);

    // 6: reset in the middle of WAIT
    set_a(1, 100); req_valid = 4'b0010; #1;
    wait_ready(g);
    check_eq("t6_grant", 32'(req_ready), 32'b0010);
    @(negedge clk);
    set_a(0, 36); set_a(2, 81); req_valid = 4'b0101;
    repeat (11) @(negedge clk);
    #1;
    check_eq("t6_busy_wait", 32'(busy), 1);
    check_eq("t6_cnt", 32'(cyc - g), 12);
    rst_ = 1'b0; #1;
    check_idle_outputs("t6_async");
    @(negedge clk); rst_ = 1'b1; #1;
    check_eq("t6_first_grant", 32'(req_ready), 32'b0001);
    g = cyc;
    @(negedge clk); req_valid = '0; #1;
    wait_resp(0, 6, r);
    check_eq("t6_latency", 32'(r - g), 20);
    @(negedge clk); #1;
    check_eq("t6_busy_done", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/sqrt_scheduler.md
Name: sqrt_scheduler

Overview:
Shares one iterative square-root datapath (12-bit operand in, 12-bit root out, fixed latency) between NREQ requesters, e.g. per-pixel shading units in the ray tracer. Arbitrates round-robin and accepts one operand at a time. Drives the datapath's start pulse and operand, waits a fixed LAT cycles, then returns the root tagged with the requester id over a valid/ready response channel. Zero operands bypass the datapath.

Parameters:
NREQ, 4, number of requesters (2..8); IDW = $clog2(NREQ) is a derived localparam
W, 12, operand/result width
LAT, 18, cycles from the sqrt_start cycle to the cycle in which sqrt_q is valid (N+2 of the datapath)

Ports:
clk  in  1  system clock
rst_  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester operand valid
req_ready  out  NREQ  per-requester accept, one-hot or zero
req_a  in  NREQ*W  packed operands; requester i at [i*W +: W]
resp_valid  out  1  result available
resp_ready  in  1  consumer accepts result
resp_id  out  IDW  requester index owning resp_q
resp_q  out  W  floor(sqrt(operand)) as returned by datapath
sqrt_start  out  1  one-cycle start pulse to datapath
sqrt_a  out  W  operand to datapath, held stable from start until capture
sqrt_q  in  W  datapath result
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_=0): state=IDLE; req_ready=0, resp_valid=0, resp_id=0, resp_q=0, sqrt_start=0, sqrt_a=0, busy=0; wait counter=0; last_grant=NREQ-1, so requester 0 has first priority.
- Transfer on a request channel = req_valid[i] & req_ready[i]. Requester holds req_a stable while valid. Dropping valid before ready is legal; the request is simply not seen.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready is combinational. Search starts at (last_grant+1) mod NREQ, wraps, picks the first i with req_valid[i], and drives req_ready[i]=1 for that one bit only. On the clock edge: latch operand into sqrt_a, latch id, set last_grant=i.
  - Operand==0: resp_q=0, go to RESP. Datapath untouched, sqrt_start stays 0.
  - Otherwise: go to ISSUE.
  - No valid: stay in IDLE; last_grant unchanged.
- ISSUE: sqrt_start=1 for exactly this cycle; load counter=LAT-1; go to WAIT.
- WAIT: decrement counter each cycle. In the cycle counter==0, register resp_q<=sqrt_q and go to RESP. sqrt_q is therefore sampled in the cycle exactly LAT cycles after the ISSUE cycle.
- RESP: resp_valid=1; resp_id and resp_q stable until the handshake. On resp_ready go to IDLE, with resp_valid low the next cycle. No new grant while in RESP; back-pressure stalls arbitration.
- Latency, accept in cycle T (nonzero operand): sqrt_start in T+1, capture at end of T+1+LAT, resp_valid from T+2+LAT. Zero operand: resp_valid from T+1.
- Throughput: one nonzero op per LAT+3 cycles with resp_ready tied high; one zero op per 2 cycles.
- req_ready is 0 in all states except IDLE. Never more than one bit set.
- sqrt_a holds its value through ISSUE, WAIT and RESP; it changes only on a grant.
- Simultaneous requests: exactly one granted per IDLE cycle; the rest keep valid and are served in later rounds.
- Reset mid-operation, any state: immediate return to reset values. Any in-flight result is discarded. Datapath output is ignored until the next ISSUE.
- sqrt_q is not checked for range; it passes through unchanged.

Test Plan:
1. Reset, then req_valid=0001, req_a[0]=144 → req_ready=0001 in cycle 0, sqrt_start in cycle 1, sqrt_a=144; resp_valid in cycle 20 with resp_id=0, resp_q=12 (bench model returns floor sqrt after LAT=18); busy high cycles 1–20.
2. All four valid, operands 4/9/16/25, resp_ready=1 → grants in order 0,1,2,3; results 2,3,4,5 with matching ids; exactly 21 cycles between consecutive grants.
3. req_valid[2] held permanently with last_grant=3 and requesters 0 and 3 also valid → grants 0,2,3,0,2,3…; no requester is granted twice while another valid one waits.
4. req_a[1]=0 → resp_valid in the cycle after the grant with resp_q=0, resp_id=1; sqrt_start never asserted.
5. resp_ready=0 for 10 cycles after resp_valid, with other requests pending → resp_id/resp_q stable, req_ready=0 throughout; the next grant comes one cycle after the resp_ready handshake.
6. rst_ pulsed low mid-WAIT (counter=7) → all outputs return to reset values asynchronously. After release, a pending request on requester 0 is granted first and the old result never appears.
